// File: rtl/la_spram_pkg.sv
// Shared types and constants for the la_spram request front-end.
package la_spram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned RD_LAT = 1;

endpackage

// File: rtl/la_spram_rspfifo.sv
// Synchronous response FIFO with push/pop/full/empty/count.
// Pop together with push is legal whenever the FIFO is not empty.
module la_spram_rspfifo
    import la_spram_pkg::*;
#(
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop = pop && !empty;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign dout   = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/la_spram_req_ctrl.sv
// Valid/ready front-end for la_spram: optional zero-fill sweep, credit-managed
// read responses covering the macro's read latency.
module la_spram_req_ctrl
    import la_spram_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 10,
    parameter int unsigned RSPDEPTH  = 3,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wmask,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          init_done,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [DW-1:0] mem_wmask,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int unsigned   OW        = $clog2(RSPDEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     init_cnt;
    logic [OW-1:0]     occ;
    logic [OW-1:0]     occ_nxt;
    logic [OW-1:0]     fifo_count;
    logic [RD_LAT-1:0] rd_pipe;
    logic              acc;
    logic              rd_acc;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign rsp_valid = !fifo_empty;

    // Accept decode, credit arithmetic and memory port muxing.
    always_comb begin
        acc       = !reset && (state == ST_RUN) && req_valid && req_ready;
        rd_acc    = acc && !req_we;
        pop       = rsp_valid && rsp_ready;
        occ_nxt   = occ + OW'(rd_acc) - OW'(pop);
        state_nxt = state;
        mem_ce    = acc;
        mem_we    = acc && req_we;
        mem_wmask = req_wmask;
        mem_addr  = req_addr;
        mem_din   = req_wdata;
        if (state == ST_INIT) begin
            mem_ce    = !reset;
            mem_we    = !reset;
            mem_wmask = '1;
            mem_din   = '0;
            mem_addr  = init_cnt;
            if (init_cnt == LAST_ADDR) begin
                state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_ZERO ? ST_INIT : ST_RUN;
            init_cnt  <= '0;
            occ       <= '0;
            rd_pipe   <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_INIT) && (init_cnt != LAST_ADDR)) begin
                init_cnt <= init_cnt + AW'(1);
            end
            occ       <= occ_nxt;
            rd_pipe   <= RD_LAT'({rd_pipe, rd_acc});
            req_ready <= (state_nxt == ST_RUN) && (occ_nxt < OW'(RSPDEPTH));
            init_done <= (state_nxt == ST_RUN);
        end
    end

    la_spram_rspfifo #(
        .DW    (DW),
        .DEPTH (RSPDEPTH)
    ) u_rspfifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_pipe[RD_LAT-1]),
        .din   (mem_dout),
        .pop   (pop),
        .dout  (rsp_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Credits guarantee a free slot for every returning read.
    assert property (@(posedge clk) disable iff (reset) !(rd_pipe[RD_LAT-1] && fifo_full));
    assert property (@(posedge clk) disable iff (reset)
        32'(occ) == 32'(fifo_count) + 32'($countones(rd_pipe)));

endmodule

// File: tb/tb_la_spram_req_ctrl.sv
// Directed bench for la_spram_req_ctrl with a behavioural la_spram model.
module tb_la_spram_req_ctrl;

    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 4;
    localparam int unsigned RSPDEPTH = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wmask = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          mem_ce;
    logic          mem_we;
    logic [DW-1:0] mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem_model [2**AW];

    always #5 clk = ~clk;

    la_spram_req_ctrl #(
        .DW        (DW),
        .AW        (AW),
        .RSPDEPTH  (RSPDEPTH),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_wmask (mem_wmask),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // la_spram model: bit-masked write, 1-cycle registered read.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                mem_model[mem_addr] <= (mem_model[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
            end else begin
                mem_dout <= mem_model[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        // 1: reset values, zero-fill sweep, early read refused
        reset = 1'b1;
        rsp_ready = 1'b1;
        idle();
        repeat (3) cyc();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_mem_ce", 32'(mem_ce), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 7) set_req(1'b1, 1'b0, AW'(7), '0, '0);
            else        idle();
            #1;
            check("init_ce", 32'(mem_ce), 32'd1);
            check("init_we", 32'(mem_we), 32'd1);
            check("init_addr", 32'(mem_addr), 32'(k));
            check("init_din", mem_din, 32'd0);
            check("init_wmask", mem_wmask, 32'hFFFF_FFFF);
            check("init_req_ready", 32'(req_ready), 32'd0);
            check("init_done_low", 32'(init_done), 32'd0);
            cyc();
        end
        idle();
        #1;
        check("run_init_done", 32'(init_done), 32'd1);
        check("run_req_ready", 32'(req_ready), 32'd1);
        check("run_no_rsp", 32'(rsp_valid), 32'd0);
        check("run_idle_ce", 32'(mem_ce), 32'd0);

        // 2: full write then read-after-write
        set_req(1'b1, 1'b1, AW'(3), 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        #1;
        check("t2_wr_ce", 32'(mem_ce), 32'd1);
        check("t2_wr_we", 32'(mem_we), 32'd1);
        check("t2_wr_din", mem_din, 32'hDEAD_BEEF);
        cyc();
        set_req(1'b1, 1'b0, AW'(3), '0, '0);
        #1;
        check("t2_rd_ce", 32'(mem_ce), 32'd1);
        check("t2_rd_we", 32'(mem_we), 32'd0);
        check("t2_rd_addr", 32'(mem_addr), 32'd3);
        cyc();
        idle();
        #1;
        check("t2_lat1_valid", 32'(rsp_valid), 32'd0);
        cyc();
        check("t2_lat2_valid", 32'(rsp_valid), 32'd1);
        check("t2_data", rsp_data, 32'hDEAD_BEEF);
        cyc();
        check("t2_drained", 32'(rsp_valid), 32'd0);

        // 3: masked write merges with old contents
        set_req(1'b1, 1'b1, AW'(3), 32'h1234_5678, 32'h0000_FFFF);
        cyc();
        set_req(1'b1, 1'b0, AW'(3), '0, '0);
        cyc();
        idle();
        cyc();
        check("t3_valid", 32'(rsp_valid), 32'd1);
        check("t3_data", rsp_data, 32'hDEAD_5678);
        cyc();

        // 4: preload, then 8 back-to-back reads streaming out
        for (int a = 0; a < 8; a++) begin
            set_req(1'b1, 1'b1, AW'(a), 32'(a * 32'h11), 32'hFFFF_FFFF);
            cyc();
        end
        for (int c = 0; c < 11; c++) begin
            if (c < 8) set_req(1'b1, 1'b0, AW'(c), '0, '0);
            else       idle();
            #1;
            if (c < 8) check("t4_req_ready", 32'(req_ready), 32'd1);
            if (c >= 2 && c < 10) begin
                check("t4_valid", 32'(rsp_valid), 32'd1);
                check("t4_data", rsp_data, 32'((c - 2) * 32'h11));
            end else begin
                check("t4_valid_low", 32'(rsp_valid), 32'd0);
            end
            cyc();
        end

        // 5: backpressure fills credits, then drains in order
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_req(1'b1, 1'b0, AW'((c < 3) ? c : 3), '0, '0);
            #1;
            check("t5_req_ready", 32'(req_ready), (c < 3) ? 32'd1 : 32'd0);
            check("t5_mem_ce", 32'(mem_ce), (c < 3) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check("t5_hold_valid", 32'(rsp_valid), 32'd1);
                check("t5_hold_data", rsp_data, 32'h0);
            end
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        check("t5_c5_req_ready", 32'(req_ready), 32'd0);
        check("t5_c5_data", rsp_data, 32'h0);
        cyc();
        check("t5_resume_ready", 32'(req_ready), 32'd1);
        check("t5_resume_ce", 32'(mem_ce), 32'd1);
        check("t5_resume_addr", 32'(mem_addr), 32'd3);
        check("t5_c6_data", rsp_data, 32'h11);
        cyc();
        idle();
        #1;
        check("t5_c7_data", rsp_data, 32'h22);
        cyc();
        check("t5_c8_valid", 32'(rsp_valid), 32'd1);
        check("t5_c8_data", rsp_data, 32'h33);
        cyc();
        check("t5_c9_valid", 32'(rsp_valid), 32'd0);

        // 6: reset with two responses pending flushes them and restarts INIT
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b0, AW'(4), '0, '0);
        cyc();
        set_req(1'b1, 1'b0, AW'(5), '0, '0);
        cyc();
        idle();
        cyc();
        check("t6_pending_valid", 32'(rsp_valid), 32'd1);
        check("t6_pending_data", rsp_data, 32'h44);
        reset = 1'b1;
        cyc();
        check("t6_rst_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_ce", 32'(mem_ce), 32'd0);
        check("t6_rst_done", 32'(init_done), 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("t6_init_addr", 32'(mem_addr), 32'(k));
            check("t6_init_we", 32'(mem_we), 32'd1);
            check("t6_no_stale", 32'(rsp_valid), 32'd0);
            cyc();
        end
        #1;
        check("t6_done", 32'(init_done), 32'd1);
        check("t6_ready", 32'(req_ready), 32'd1);
        check("t6_final_valid", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
